// File: rtl/sc_pkg.sv
// Shared encodings for the single-cycle run harness: controller states and
// the two-bit run status codes reported to the host.
package sc_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_LOADED = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [1:0] ST_NONE    = 2'b00;
  localparam logic [1:0] ST_HALT    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_OVF     = 2'b11;

endpackage

// File: rtl/sc_halt_detect.sv
// Flags a halt once the core PC has stayed unchanged for HALT_CYCLES
// consecutive running cycles (a jal x0,0 self-loop).
module sc_halt_detect #(
  parameter int HALT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic [31:0] pc_i,
  output logic        halt_o
);

  localparam int CW = $clog2(HALT_CYCLES) + 1;
  localparam logic [CW-1:0] HALT_AT = CW'(HALT_CYCLES - 1);

  logic [31:0]   pc_q;
  logic [CW-1:0] same_cnt_q, same_cnt_d;
  logic          primed_q;
  logic          match;

  // The first running cycle has no previous PC, so it never counts as a repeat.
  assign match = primed_q && (pc_i == pc_q);

  always_comb begin
    same_cnt_d = '0;
    if (match) begin
      same_cnt_d = (same_cnt_q == HALT_AT) ? same_cnt_q : same_cnt_q + 1'b1;
    end
  end

  assign halt_o = en_i && match && (same_cnt_d == HALT_AT);

  always_ff @(posedge clk) begin
    if (!rst_ni || !en_i) begin
      pc_q       <= '0;
      same_cnt_q <= '0;
      primed_q   <= 1'b0;
    end else begin
      pc_q       <= pc_i;
      same_cnt_q <= same_cnt_d;
      primed_q   <= 1'b1;
    end
  end

endmodule

// File: rtl/sc_run_controller.sv
// Run harness for the single-cycle core: streams an image into instruction
// memory, releases the core, and stops on halt or cycle budget.
module sc_run_controller
  import sc_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 6,
  parameter int RUN_CYCLES  = 50,
  parameter int HALT_CYCLES = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  input  logic                  start,
  input  logic                  clear,
  input  logic [31:0]           pc,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  core_rst,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            status,
  output logic [ADDR_WIDTH:0]   words_loaded,
  output logic [CNT_WIDTH-1:0]  cycle_count
);

  localparam logic [ADDR_WIDTH-1:0] PTR_MAX = '1;
  localparam logic [CNT_WIDTH-1:0]  RUN_LIM = CNT_WIDTH'(RUN_CYCLES);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   words_q, words_d;
  logic [CNT_WIDTH-1:0]  cycle_q, cycle_d, cycle_inc;
  logic [1:0]            status_q, status_d;
  logic                  core_rst_q, core_rst_d;
  logic                  accept;
  logic                  halt;

  sc_halt_detect #(
    .HALT_CYCLES(HALT_CYCLES)
  ) u_halt (
    .clk   (clk),
    .rst_ni(rst),
    .en_i  (core_rst_q),
    .pc_i  (pc),
    .halt_o(halt)
  );

  assign load_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign accept     = load_valid && load_ready;
  assign cycle_inc  = (cycle_q == '1) ? cycle_q : cycle_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    words_d    = words_q;
    cycle_d    = cycle_q;
    status_d   = status_q;
    core_rst_d = core_rst_q;
    case (state_q)
      S_IDLE, S_LOAD: begin
        if (accept) begin
          words_d = words_q + 1'b1;
          // The pointer parks on the last word so an overflow never wraps.
          if (wr_ptr_q != PTR_MAX) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
          if (load_last) begin
            state_d = S_LOADED;
          end else if (wr_ptr_q == PTR_MAX) begin
            state_d  = S_DONE;
            status_d = ST_OVF;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOADED: begin
        if (start) begin
          state_d    = S_RUN;
          core_rst_d = 1'b1;
        end
      end
      S_RUN: begin
        cycle_d = cycle_inc;
        // Halt is checked first so it wins when both end the same cycle.
        if (halt) begin
          state_d    = S_DONE;
          status_d   = ST_HALT;
          core_rst_d = 1'b0;
        end else if (cycle_inc >= RUN_LIM) begin
          state_d    = S_DONE;
          status_d   = ST_TIMEOUT;
          core_rst_d = 1'b0;
        end
      end
      S_DONE: begin
        if (clear) begin
          state_d  = S_IDLE;
          wr_ptr_d = '0;
          words_d  = '0;
          cycle_d  = '0;
          status_d = ST_NONE;
        end
      end
      default: begin
        state_d    = S_IDLE;
        core_rst_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      words_q    <= '0;
      cycle_q    <= '0;
      status_q   <= ST_NONE;
      core_rst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      words_q    <= words_d;
      cycle_q    <= cycle_d;
      status_q   <= status_d;
      core_rst_q <= core_rst_d;
    end
  end

  assign mem_we       = accept;
  assign mem_addr     = wr_ptr_q;
  assign mem_wdata    = load_data;
  assign core_rst     = core_rst_q;
  assign busy         = (state_q == S_LOAD) || (state_q == S_RUN);
  assign done         = (state_q == S_DONE);
  assign status       = status_q;
  assign words_loaded = words_q;
  assign cycle_count  = cycle_q;

endmodule

// File: tb/tb_sc_run_controller.sv
// Self-checking bench for sc_run_controller: table-driven runs, overflow,
// ignored-input and mid-run reset sequences, plus randomized PC traces.
module tb_sc_run_controller;
  import sc_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int RUNC  = 50;
  localparam int HALTC = 4;
  localparam int CW    = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          loadValid = 1'b0;
  logic [DW-1:0] loadData = '0;
  logic          loadLast = 1'b0;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic [31:0]   pc = '0;
  logic          loadReady, memWe, coreRst, busy, done;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWdata;
  logic [1:0]    status;
  logic [AW:0]   wordsLoaded;
  logic [CW-1:0] cycleCount;

  sc_run_controller #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RUN_CYCLES(RUNC),
    .HALT_CYCLES(HALTC), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .load_valid(loadValid), .load_ready(loadReady),
    .load_data(loadData), .load_last(loadLast), .start(start), .clear(clear),
    .pc(pc), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
    .core_rst(coreRst), .busy(busy), .done(done), .status(status),
    .words_loaded(wordsLoaded), .cycle_count(cycleCount)
  );

  always #5 clk = ~clk;

  // Instruction memory stand-in, written the same way the real memory would be.
  logic [DW-1:0] imem [0:DEPTH-1];
  int            wrTotal = 0;
  always @(posedge clk) begin
    if (memWe) begin
      imem[memAddr] <= memWdata;
      wrTotal       <= wrTotal + 1;
    end
  end

  int            tests = 0;
  int            failed = 0;
  logic [DW-1:0] expData [0:DEPTH-1];
  logic [31:0]   pcSeq [0:RUNC+15];

  typedef struct {
    int         nWords;
    int         stuckFrom;
    logic [1:0] expStatus;
    int         expCycles;
    bit         injectIgnored;
  } runVec_t;

  runVec_t tbl [6];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic l,
                               input logic s, input logic c);
    loadValid = v;
    loadData  = d;
    loadLast  = l;
    start     = s;
    clear     = c;
  endtask

  task automatic fillPc(input int stuckFrom);
    for (int k = 0; k <= RUNC + 15; k++) begin
      pcSeq[k] = 32'h100 + 32'(4 * k);
      if (stuckFrom > 0 && k >= stuckFrom) pcSeq[k] = pcSeq[stuckFrom];
    end
  endtask

  task automatic fillRandomPc();
    int tail;
    tail = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 55)) : 0;
    pcSeq[0] = 32'h200;
    for (int k = 1; k <= RUNC + 15; k++) begin
      if (tail > 0 && k > tail) pcSeq[k] = pcSeq[k-1];
      else if (k > 1 && $urandom_range(0, 9) < 3) pcSeq[k] = pcSeq[k-1];
      else pcSeq[k] = 32'h200 + 32'(4 * $urandom_range(0, 255));
    end
  endtask

  // Reference: the run stops at the first counted cycle that completes a
  // stretch of HALTC equal PCs, otherwise after RUNC counted cycles.
  task automatic modelRun(output logic [1:0] st, output int cyc);
    int runLen;
    runLen = 0;
    st  = ST_TIMEOUT;
    cyc = RUNC;
    for (int c = 1; c <= RUNC; c++) begin
      if (c > 1 && pcSeq[c] == pcSeq[c-1]) runLen++;
      else runLen = 1;
      if (runLen >= HALTC) begin
        st  = ST_HALT;
        cyc = c;
        return;
      end
    end
  endtask

  task automatic loadImage(input int n, input bit withLast);
    int base;
    base = wrTotal;
    for (int i = 0; i < n; i++) begin
      expData[i] = $urandom;
      applyStimulus(1'b1, expData[i], withLast && (i == n - 1), 1'b0, 1'b0);
      #1;
      checkOutput("load mem_we", 64'(memWe), 64'(1));
      checkOutput("load mem_addr", 64'(memAddr), 64'(i));
      step();
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("write count", 64'(wrTotal - base), 64'(n));
    checkOutput("words_loaded", 64'(wordsLoaded), 64'(n));
    for (int i = 0; i < n; i++) checkOutput("imem word", 64'(imem[i]), 64'(expData[i]));
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " load_ready"}, 64'(loadReady), 64'(1));
    checkOutput({tag, " busy"}, 64'(busy), 64'(0));
    checkOutput({tag, " done"}, 64'(done), 64'(0));
    checkOutput({tag, " core_rst"}, 64'(coreRst), 64'(0));
    checkOutput({tag, " status"}, 64'(status), 64'(ST_NONE));
    checkOutput({tag, " words_loaded"}, 64'(wordsLoaded), 64'(0));
    checkOutput({tag, " cycle_count"}, 64'(cycleCount), 64'(0));
    checkOutput({tag, " mem_addr"}, 64'(memAddr), 64'(0));
  endtask

  task automatic doRun(input int n, input logic [1:0] expStatus, input int expCycles,
                       input bit injectIgnored, input int resetAt);
    int endEdge;
    int base;
    loadImage(n, 1'b1);
    checkOutput("loaded load_ready", 64'(loadReady), 64'(0));
    checkOutput("loaded busy", 64'(busy), 64'(0));
    checkOutput("loaded core_rst", 64'(coreRst), 64'(0));
    base = wrTotal;
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    pc = pcSeq[1];
    checkOutput("start core_rst", 64'(coreRst), 64'(1));
    checkOutput("start busy", 64'(busy), 64'(1));
    endEdge = 0;
    for (int k = 1; k <= RUNC + 10; k++) begin
      step();
      if (done) begin
        endEdge = k;
        break;
      end
      if (resetAt != 0 && k == resetAt) begin
        rst = 1'b0;
        step();
        checkIdle("midrun reset");
        rst = 1'b1;
        step();
        return;
      end
      if (injectIgnored && k == 5) begin
        applyStimulus(1'b1, $urandom, 1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("run load_ready", 64'(loadReady), 64'(0));
        checkOutput("run mem_we", 64'(memWe), 64'(0));
      end
      if (injectIgnored && k == 8) begin
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("clear ignored busy", 64'(busy), 64'(1));
        checkOutput("clear ignored cycles", 64'(cycleCount), 64'(8));
      end
      pc = pcSeq[k+1];
    end
    checkOutput("run end edge", 64'(endEdge), 64'(expCycles));
    checkOutput("run status", 64'(status), 64'(expStatus));
    checkOutput("run cycle_count", 64'(cycleCount), 64'(expCycles));
    checkOutput("run core_rst", 64'(coreRst), 64'(0));
    checkOutput("run busy", 64'(busy), 64'(0));
    checkOutput("run words_loaded", 64'(wordsLoaded), 64'(n));
    checkOutput("no writes in run", 64'(wrTotal - base), 64'(0));
    step();
    checkOutput("done hold", 64'(done), 64'(1));
    checkOutput("done hold cycles", 64'(cycleCount), 64'(expCycles));
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkIdle("after clear");
  endtask

  initial begin
    logic [1:0] mSt;
    int         mCyc;
    int         base;

    tbl[0] = '{8,  0,  ST_TIMEOUT, 50, 1'b1};
    tbl[1] = '{5,  10, ST_HALT,    13, 1'b0};
    tbl[2] = '{1,  1,  ST_HALT,    4,  1'b0};
    tbl[3] = '{3,  47, ST_HALT,    50, 1'b0};
    tbl[4] = '{4,  48, ST_TIMEOUT, 50, 1'b0};
    tbl[5] = '{12, 30, ST_HALT,    33, 1'b0};

    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    checkIdle("reset");
    checkOutput("reset mem_we", 64'(memWe), 64'(0));
    loadValid = 1'b1;
    #1;
    checkOutput("reset mem_we follows valid", 64'(memWe), 64'(1));
    step();
    loadValid = 1'b0;
    checkIdle("reset with valid");
    rst = 1'b1;
    step();

    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkIdle("start in idle");

    for (int i = 0; i < 6; i++) begin
      fillPc(tbl[i].stuckFrom);
      doRun(tbl[i].nWords, tbl[i].expStatus, tbl[i].expCycles, tbl[i].injectIgnored, 0);
    end

    base = wrTotal;
    loadImage(DEPTH, 1'b0);
    checkOutput("ovf done", 64'(done), 64'(1));
    checkOutput("ovf status", 64'(status), 64'(ST_OVF));
    checkOutput("ovf core_rst", 64'(coreRst), 64'(0));
    checkOutput("ovf busy", 64'(busy), 64'(0));
    applyStimulus(1'b1, $urandom, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("ovf load_ready", 64'(loadReady), 64'(0));
    checkOutput("ovf mem_we", 64'(memWe), 64'(0));
    step();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf start ignored", 64'(coreRst), 64'(0));
    checkOutput("ovf total writes", 64'(wrTotal - base), 64'(DEPTH));
    checkOutput("ovf imem[0] kept", 64'(imem[0]), 64'(expData[0]));
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkIdle("ovf clear");

    fillPc(0);
    doRun(6, ST_TIMEOUT, RUNC, 1'b0, 20);
    doRun(7, ST_TIMEOUT, RUNC, 1'b0, 0);

    repeat (8) begin
      fillRandomPc();
      modelRun(mSt, mCyc);
      doRun(int'($urandom_range(1, 30)), mSt, mCyc, 1'b0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
